// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline register stage.
// The occupancy encoding is common to the top level and any bench that wants to name states.
package pipe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the stage: load enable plus a per-bit masked clear.
// Clear wins over load so a squashed cycle never lets new data in.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0]  CLR_MASK = '1,
    parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= (r_q & ~CLR_MASK) | (CLR_VAL & CLR_MASK);
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_reg_stage.sv
// Ready/valid pipeline register with optional skid entry, stall/flush control
// and saturating stall/flush cycle counters.
module pipe_reg_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0]  CLR_MASK = '1,
    parameter logic [DATA_W-1:0]  CLR_VAL  = '0,
    parameter bit                 SKID     = 1'b1,
    parameter int                 CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int              NSLOT   = SKID ? 2 : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_e              r_state;
    occ_e              w_state_next;
    logic              r_in_rdy;
    logic              w_enq;
    logic              w_deq;
    logic              w_main_ld;
    logic              w_skid_ld;
    logic [DATA_W-1:0] w_main_d;
    logic [DATA_W-1:0] w_main_q;
    logic [DATA_W-1:0] w_skid_q;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_slot_ld [NSLOT];
    logic [DATA_W-1:0] w_slot_d  [NSLOT];
    logic [DATA_W-1:0] w_slot_q  [NSLOT];

    assign out_valid = (r_state != EMPTY) & ~stall;
    assign out_data  = w_main_q;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // r_in_rdy also keeps in_ready low until the first edge out of reset.
    generate
        if (SKID) begin : g_rdy_skid
            assign in_ready = r_in_rdy & ~stall;
        end else begin : g_rdy_pass
            assign in_ready = r_in_rdy & ((r_state == EMPTY) | out_ready) & ~stall;
        end
    endgenerate

    assign w_enq = in_valid & in_ready & ~flush;
    assign w_deq = out_valid & out_ready & ~flush;

    always_comb begin
        w_state_next = r_state;
        w_main_ld    = 1'b0;
        w_skid_ld    = 1'b0;
        w_main_d     = in_data;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_enq) begin
                        w_state_next = ONE;
                        w_main_ld    = 1'b1;
                    end
                end
                ONE: begin
                    if (w_enq && w_deq) begin
                        w_main_ld = 1'b1;
                    end else if (w_enq && SKID) begin
                        w_state_next = TWO;
                        w_skid_ld    = 1'b1;
                    end else if (w_deq) begin
                        w_state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (w_deq) begin
                        w_state_next = ONE;
                        w_main_ld    = 1'b1;
                        w_main_d     = w_skid_q;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_in_rdy <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_in_rdy <= (w_state_next != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign w_slot_ld[0] = w_main_ld;
    assign w_slot_d[0]  = w_main_d;
    assign w_main_q     = w_slot_q[0];

    generate
        if (SKID) begin : g_skid
            assign w_slot_ld[1] = w_skid_ld;
            assign w_slot_d[1]  = in_data;
            assign w_skid_q     = w_slot_q[1];
        end else begin : g_no_skid
            assign w_skid_q = '0;
        end

        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            pipe_slot #(
                .DATA_W   (DATA_W),
                .CLR_MASK (CLR_MASK),
                .CLR_VAL  (CLR_VAL)
            ) u_slot (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (w_slot_ld[gi]),
                .i_clr  (flush),
                .i_d    (w_slot_d[gi]),
                .o_q    (w_slot_q[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg_stage.sv
// Bench for pipe_reg_stage: three instances (default, masked flush with 4-bit counters,
// no skid) share one stimulus stream; a per-instance queue tracks accepted payloads.
module tb_pipe_reg_stage;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        stall     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data   = 16'h0000;

    logic        ir [3];
    logic        ov [3];
    logic [15:0] od [3];
    logic [15:0] sc0, fc0, sc2, fc2;
    logic [3:0]  sc1, fc1;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [15:0] sbq [3][$];

    always #5 clk = ~clk;

    pipe_reg_stage dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipe_reg_stage #(.CLR_MASK(16'h00FF), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_reg_stage #(.SKID(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready),
        .stall_cnt(sc2), .flush_cnt(fc2)
    );

    // Scoreboard update at the falling edge, where inputs and outputs are stable.
    task automatic sb_sample();
        logic [15:0] e;
        if (!rst_n) begin
            exp_stall = 0;
            exp_flush = 0;
            for (int i = 0; i < 3; i++) sbq[i].delete();
        end else begin
            if (stall) exp_stall++;
            if (flush) exp_flush++;
            for (int i = 0; i < 3; i++) begin
                if (flush) begin
                    sbq[i].delete();
                end else begin
                    if (ov[i] && out_ready) begin
                        checks++;
                        if (sbq[i].size() == 0) begin
                            errors++;
                            $display("FAIL sb_pop dut%0d: got out_data=%h, required no output (nothing queued)", i, od[i]);
                        end else begin
                            e = sbq[i].pop_front();
                            if (od[i] !== e) begin
                                errors++;
                                $display("FAIL sb_pop dut%0d: got out_data=%h, required %h", i, od[i], e);
                            end else begin
                                $display("txn dut%0d out_data=%h", i, od[i]);
                            end
                        end
                    end
                    if (in_valid && ir[i]) sbq[i].push_back(in_data);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || ir[i] !== 1'b0 || od[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_out dut%0d: got valid=%b ready=%b data=%h, required 0 0 0000", i, ov[i], ir[i], od[i]);
            end
        end
        checks++;
        if (sc0 !== 16'h0 || fc0 !== 16'h0 || sc1 !== 4'h0 || fc1 !== 4'h0 || sc2 !== 16'h0 || fc2 !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %h %h %h %h %h %h, required all zero", sc0, fc0, sc1, fc1, sc2, fc2);
        end
        step();
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_edge: got in_ready=%b, required 0", ir[0]);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ir[i] !== 1'b1) begin
                errors++;
                $display("FAIL rdy_after_edge dut%0d: got in_ready=%b, required 1", i, ir[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h1000 + 16'(k);
            step();
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== 16'h1000 + 16'(k) || ir[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: got valid=%b data=%h ready=%b, required 1 %h 1", k, ov[0], od[0], ir[0], 16'h1000 + 16'(k));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (ov[0] !== 1'b0 || sbq[0].size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b queued=%0d, required 0 0", ov[0], sbq[0].size());
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hAAAA;
        step();
        in_data   = 16'hBBBB;
        step();
        in_valid  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== 16'hAAAA) begin
                errors++;
                $display("FAIL bp_full[%0d]: got ready=%b valid=%b data=%h, required 0 1 aaaa", k, ir[0], ov[0], od[0]);
            end
            if (k == 0) step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 16'hBBBB || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got valid=%b data=%h ready=%b, required 1 bbbb 1", ov[0], od[0], ir[0]);
        end
        step();
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got valid=%b, required 0", ov[0]);
        end
    endtask

    task automatic test_masked_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h12F3;
        step();
        flush     = 1'b1;
        in_data   = 16'h5555;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ov[2] !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b%b%b, required 000", ov[0], ov[1], ov[2]);
        end
        checks++;
        if (od[1] !== 16'h1200 || od[0] !== 16'h0000) begin
            errors++;
            $display("FAIL flush_data: got masked=%h full=%h, required 1200 0000", od[1], od[0]);
        end
        checks++;
        if (fc1 !== 4'd1 || fc0 !== 16'(exp_flush)) begin
            errors++;
            $display("FAIL flush_cnt: got %0d %0d, required 1 %0d", fc1, fc0, exp_flush);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (ov[1] !== 1'b0 || od[1] === 16'h5555) begin
            errors++;
            $display("FAIL flush_discard: got valid=%b data=%h, required 0 1200", ov[1], od[1]);
        end
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0042;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            stall = 1'b1;
            flush = (c == 1);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ov[i] !== 1'b0 || ir[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold[%0d] dut%0d: got valid=%b ready=%b, required 0 0", c, i, ov[i], ir[i]);
                end
            end
            step();
        end
        stall = 1'b0;
        flush = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== 1'b0) begin
                errors++;
                $display("FAIL stall_flush_empty dut%0d: got valid=%b, required 0", i, ov[i]);
            end
        end
        checks++;
        if (sc0 !== 16'd3 || sc1 !== 4'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d %0d, required 3 3", sc0, sc1);
        end
    endtask

    task automatic test_saturation();
        int m;
        stall = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            m = (exp_stall > 15) ? 15 : exp_stall;
            checks++;
            if (sc1 !== 4'(m)) begin
                errors++;
                $display("FAIL sat[%0d]: got stall_cnt=%0d, required %0d", c, sc1, m);
            end
        end
        stall = 1'b0;
        checks++;
        if (sc0 !== 16'(exp_stall) || exp_stall != 23) begin
            errors++;
            $display("FAIL wide_cnt: got stall_cnt=%0d, required 23", sc0);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0111;
        step();
        in_data   = 16'h0222;
        step();
        in_valid  = 1'b0;
        checks++;
        if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== 16'h0111) begin
            errors++;
            $display("FAIL ar_two: got ready=%b valid=%b data=%h, required 0 1 0111", ir[0], ov[0], od[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b0 || od[0] !== 16'h0 || sc0 !== 16'h0 || fc0 !== 16'h0 || sc1 !== 4'h0 || fc1 !== 4'h0) begin
            errors++;
            $display("FAIL ar_async: got valid=%b ready=%b data=%h cnt=%0d/%0d/%0d/%0d, required all zero",
                     ov[0], ir[0], od[0], sc0, fc0, sc1, fc1);
        end
        step();
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL ar_rdy_pre: got in_ready=%b, required 0", ir[0]);
        end
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || sbq[i].size() != 0) begin
                errors++;
                $display("FAIL ar_release dut%0d: got ready=%b valid=%b queued=%0d, required 1 0 0", i, ir[i], ov[i], sbq[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_masked_flush();
        test_stall_flush();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg_stage.md
PIPE_REG_STAGE -- requirements
Module: pipe_reg_stage

Interface
REQ-001 Parameter DATA_W, 16, payload width in bits.
REQ-002 Parameter CLR_MASK, all ones, per-bit flush mask (1 = bit forced to CLR_VAL on flush, 0 = bit retained).
REQ-003 Parameter CLR_VAL, 0, flush value for masked bits.
REQ-004 Parameter SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-005 Parameter CNT_W, 16, width of the performance counters.
REQ-006 clk  input  1  sole clock, all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 stall  input  1  hazard hold; freezes all entries.
REQ-009 flush  input  1  squash all held entries.
REQ-010 in_valid  input  1  upstream payload valid.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 in_ready  output  1  stage can accept a payload.
REQ-013 out_valid  output  1  downstream payload valid.
REQ-014 out_data  output  DATA_W  downstream payload, taken from the main entry.
REQ-015 out_ready  input  1  downstream accepts the payload.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with stall=1.
REQ-017 flush_cnt  output  CNT_W  saturating count of cycles with flush=1.

Function
REQ-018 Enqueue occurs when in_valid & in_ready; dequeue occurs when out_valid & out_ready.
REQ-019 Occupancy state is EMPTY, ONE or TWO; TWO is reachable only when SKID=1.
REQ-020 EMPTY: enqueue -> ONE (payload to main entry).
REQ-021 ONE: enqueue only -> TWO (payload to skid entry); dequeue only -> EMPTY; enqueue and dequeue together -> ONE (payload to main entry).
REQ-022 TWO: dequeue -> ONE with the skid entry moved to the main entry; enqueue is impossible in TWO.
REQ-023 SKID=1: in_ready is registered and equals (state != TWO).
REQ-024 SKID=0: in_ready = (state == EMPTY) | out_ready, and state ONE with enqueue and no dequeue holds.
REQ-025 out_valid = (state != EMPTY) & ~stall; in_ready is forced to 0 while stall=1.
REQ-026 stall=1 holds state and both entries unchanged, so no enqueue or dequeue occurs.
REQ-027 flush=1 -> state EMPTY next cycle and masked bits of both entries set to CLR_VAL; unmasked bits retained.
REQ-028 Flush has priority over stall and over a same-cycle enqueue or dequeue; a payload offered in a flush cycle is discarded.
REQ-029 Data ordering is strict FIFO; out_data is stable while out_valid=1 and out_ready=0.
REQ-030 Latency is one cycle from enqueue into EMPTY to out_valid=1.
REQ-031 Counters increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 without wrap.

Reset
REQ-032 When rst_n=0, the state is EMPTY immediately.
REQ-033 Reset output values: out_valid=0, out_data=0, counters=0, and in_ready=0; both entries are cleared to 0.
REQ-034 SKID=1: in_ready rises on the first clock edge after rst_n is deasserted.
REQ-035 Reset mid-transfer discards all held payloads with no partial output.

Structure
REQ-036 Shared package pipe_pkg holds the occupancy enum typedef (EMPTY/ONE/TWO) and the default DATA_W and CNT_W constants.
REQ-037 Each entry is one instance of sub-module pipe_slot, a DATA_W register with load enable and masked clear (CLR_MASK/CLR_VAL), asynchronous active-low reset.
REQ-038 The top level contains the occupancy FSM, ready/valid logic and counters.

Verification
REQ-039 Back-to-back flow: SKID=1, out_ready=1, in_data 0x1000..0x1004 on 5 cycles -> out_data 0x1000..0x1004 on consecutive cycles starting 1 cycle later; in_ready stays 1.
REQ-040 Backpressure: out_ready=0, in_data 0xAAAA then 0xBBBB -> state TWO, in_ready=0; release out_ready -> outputs 0xAAAA then 0xBBBB, no loss or duplication.
REQ-041 Masked flush: CLR_MASK=0x00FF, entry 0x12F3, flush=1 with in_valid=1 and in_data 0x5555 -> out_valid=0, main entry 0x1200, 0x5555 never appears, flush_cnt=1.
REQ-042 Stall over flush: stall=1 for 3 cycles with entry 0x0042, flush on cycle 2 -> out_valid=0 throughout, state EMPTY after flush, stall_cnt=3.
REQ-043 Saturation: CNT_W=4, stall=1 for 20 cycles -> stall_cnt reaches 15 and holds.
REQ-044 Asynchronous reset: rst_n=0 mid-cycle in state TWO -> out_valid=0 and counters=0 before the next edge; in_ready=1 on the first edge after release.
